instr_issue: RTL

Instruction fetch/issue unit feeding the control unit: holds the program counter and fetches 16-bit Thumb-style instructions from instruction memory. Presents each one to the decoder with a one-cycle enable, then samples the decoder's branch, self-instruction and end-program outputs to choose the next PC. Injected self-instructions (push/pop second half) are replayed without advancing the PC. Sits between the instruction memory and the control unit's `in` / `cu_input_en_i` inputs.

---
 rtl/instr_issue.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/instr_issue.sv
// ---------------------------------------------------------------------------
// instr_issue
//   Instruction fetch/issue unit. Holds the program counter, fetches 16-bit
//   Thumb-style words from instruction memory, presents each one to the
//   decoder for one enable cycle, then uses the decoder's branch / self
//   instruction / end-of-program outputs to pick the next PC. Injected words
//   (second half of push/pop) are replayed without advancing the PC.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   imem_req_o/imem_addr_o   fetch request pulse and byte address (= pc_o)
//   imem_data_i/imem_valid_i fetched word and its valid strobe
//   instr_o/instr_en_o       instruction and enable towards the decoder
//   pc_o                     address of the instruction held/issued
//   branch_i, branch_off_i,
//   sign_extend_en_i         decoder branch decision and offset selection
//   self_instruct_i/_en_i    injected instruction word and its request
//   end_program_i            decoder saw the terminating 16'h0000
//   stall_i                  hold the current issue cycle
//   halted_o                 program has ended
// ---------------------------------------------------------------------------
module instr_issue #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic [15:0]         imem_data_i,
  input  logic                imem_valid_i,
  output logic [15:0]         instr_o,
  output logic                instr_en_o,
  output logic [PC_WIDTH-1:0] pc_o,
  input  logic                branch_i,
  input  logic [10:0]         branch_off_i,
  input  logic                sign_extend_en_i,
  input  logic [15:0]         self_instruct_i,
  input  logic                self_instruct_en_i,
  input  logic                end_program_i,
  input  logic                stall_i,
  output logic                halted_o
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_INJECT = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(3'd2);
  localparam logic [PC_WIDTH-1:0] PC_FOUR = PC_WIDTH'(3'd4);

  state_t              state_r;
  state_t              next_state_s;
  logic [PC_WIDTH-1:0] pc_r;
  logic [15:0]         instr_r;
  logic                req_r;
  logic                instr_en_s;
  logic                halted_s;

  // Branch target PC + 4 + (sext(off) << 1); the short form uses off[7:0].
  // Arithmetic is modulo 2^PC_WIDTH so wrap-around is silent.
  function automatic logic [PC_WIDTH-1:0] branch_target(
    input logic [PC_WIDTH-1:0] pc,
    input logic [10:0]         off,
    input logic                short_off
  );
    logic [PC_WIDTH-1:0] ext;
    if (short_off) begin
      ext = {{(PC_WIDTH-8){off[7]}}, off[7:0]};
    end else begin
      ext = {{(PC_WIDTH-11){off[10]}}, off};
    end
    return pc + PC_FOUR + {ext[PC_WIDTH-2:0], 1'b0};
  endfunction

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. FETCH only moves on once the registered request has
  // actually been presented, so the cycle straight after reset issues no
  // request and the first pulse follows the reset release.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (req_r) next_state_s = ST_WAIT;
        else       next_state_s = ST_FETCH;
      end
      ST_WAIT: begin
        if (imem_valid_i) next_state_s = ST_ISSUE;
        else              next_state_s = ST_WAIT;
      end
      ST_ISSUE: begin
        if (stall_i)                 next_state_s = ST_ISSUE;
        else if (end_program_i)      next_state_s = ST_HALT;
        else if (self_instruct_en_i) next_state_s = ST_INJECT;
        else                         next_state_s = ST_FETCH;
      end
      ST_INJECT: begin
        if (stall_i) next_state_s = ST_INJECT;
        else         next_state_s = ST_FETCH;
      end
      ST_HALT:  next_state_s = ST_HALT;
      default:  next_state_s = ST_FETCH;
    endcase
  end

  // Output decode from the current state only.
  always_comb begin
    instr_en_s = 1'b0;
    halted_s   = 1'b0;
    case (state_r)
      ST_ISSUE, ST_INJECT: instr_en_s = 1'b1;
      ST_HALT:             halted_s   = 1'b1;
      default: begin
        instr_en_s = 1'b0;
        halted_s   = 1'b0;
      end
    endcase
  end

  // PC, instruction holding register and fetch request pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_r    <= RESET_PC;
      instr_r <= 16'h0000;
      req_r   <= 1'b0;
    end else begin
      // The request is high for exactly the one cycle spent in FETCH.
      req_r <= (next_state_s == ST_FETCH);
      case (state_r)
        ST_WAIT: begin
          if (imem_valid_i) instr_r <= imem_data_i;
        end
        ST_ISSUE: begin
          if (!stall_i && !end_program_i) begin
            // An injection replays at the same PC; the +2 happens on leaving INJECT.
            if (self_instruct_en_i) begin
              instr_r <= self_instruct_i;
            end else if (branch_i) begin
              pc_r <= branch_target(pc_r, branch_off_i, sign_extend_en_i);
            end else begin
              pc_r <= pc_r + PC_STEP;
            end
          end
        end
        ST_INJECT: begin
          if (!stall_i) pc_r <= pc_r + PC_STEP;
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_req_o  = req_r;
  assign imem_addr_o = pc_r;
  assign pc_o        = pc_r;
  assign instr_o     = instr_r;
  assign instr_en_o  = instr_en_s;
  assign halted_o    = halted_s;

endmodule
